simt_reconv_stack: RTL and testbench

SIMT_RECONV_STACK -- requirements
Module: simt_reconv_stack

---
 rtl/simt_reconv_stack.sv | 130 +++++++++++++
 tb/tb_simt_reconv_stack.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/simt_reconv_stack.sv
// SIMT reconvergence stack: per-warp stack of {mask, sync, addr} entries.
// The top entry drives the active mask; a PC match on the top sync address
// pops the entry (reconvergence). Overflow/underflow are sticky flags.
module simt_reconv_stack #(
   parameter int THREADS = 4,
   parameter int DEPTH   = 16,
   parameter int WORD_W  = 32,
   localparam int CW     = $clog2(DEPTH+1),
   localparam int IW     = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                RST,
   input  logic                push_i,
   input  logic                pop_i,
   input  logic [THREADS-1:0]  new_mask_i,
   input  logic [WORD_W-1:0]   new_sync_i,
   input  logic [WORD_W-1:0]   new_addr_i,
   input  logic                pc_valid_i,
   input  logic [WORD_W-1:0]   pc_i,
   input  logic                err_clr_i,
   output logic [THREADS-1:0]  top_mask_o,
   output logic [WORD_W-1:0]   top_sync_o,
   output logic [WORD_W-1:0]   top_addr_o,
   output logic                reconv_o,
   output logic [CW-1:0]       cnt_o,
   output logic [CW-1:0]       hwm_o,
   output logic                full_o,
   output logic                empty_o,
   output logic                ovf_o,
   output logic                udf_o
);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [THREADS-1:0] mask_mem [DEPTH];
   logic [WORD_W-1:0]  sync_mem [DEPTH];
   logic [WORD_W-1:0]  addr_mem [DEPTH];

   logic [CW-1:0] cnt_q, cnt_d, hwm_q, hwm_d;
   logic          ovf_q, ovf_d, udf_q, udf_d;
   logic          empty, full, reconv_hit, pop_eff;
   logic          wr_en, ovf_set, udf_set;
   logic [IW-1:0] wr_idx, top_idx;

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == DEPTH_C);
   // Guarded so an empty stack never forms an out-of-range index.
   assign top_idx = empty ? '0 : IW'(cnt_q - 1'b1);

   // Top-of-stack view; an empty stack means all threads active.
   always_comb begin
      top_mask_o = '1;
      top_sync_o = '0;
      top_addr_o = '0;
      if (!empty) begin
         top_mask_o = mask_mem[top_idx];
         top_sync_o = sync_mem[top_idx];
         top_addr_o = addr_mem[top_idx];
      end
   end

   assign reconv_hit = pc_valid_i & ~empty & (pc_i == top_sync_o);
   assign pop_eff    = pop_i | reconv_hit;

   // Next-state: push/pop arbitration, saturating count, error detection.
   always_comb begin
      cnt_d   = cnt_q;
      wr_en   = 1'b0;
      wr_idx  = IW'(cnt_q);
      ovf_set = 1'b0;
      udf_set = 1'b0;
      if (push_i && pop_eff) begin
         wr_en = 1'b1;
         if (empty) begin
            // Nothing to replace: behaves as a push but flags the bad pop.
            wr_idx  = '0;
            cnt_d   = CW'(1);
            udf_set = 1'b1;
         end else begin
            wr_idx = top_idx;
         end
      end else if (push_i) begin
         if (full) begin
            ovf_set = 1'b1;
         end else begin
            wr_en = 1'b1;
            cnt_d = cnt_q + 1'b1;
         end
      end else if (pop_eff) begin
         if (empty) udf_set = 1'b1;
         else       cnt_d   = cnt_q - 1'b1;
      end
      ovf_d = ovf_set | (ovf_q & ~err_clr_i);
      udf_d = udf_set | (udf_q & ~err_clr_i);
      hwm_d = (cnt_d > hwm_q) ? cnt_d : hwm_q;
   end

   // Control state with synchronous reset overriding everything.
   always_ff @(posedge clk) begin
      if (RST) begin
         cnt_q <= '0;
         hwm_q <= '0;
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         hwm_q <= hwm_d;
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   // Entry storage; contents are not reset, validity comes from cnt.
   always_ff @(posedge clk) begin
      if (wr_en && !RST) begin
         mask_mem[wr_idx] <= new_mask_i;
         sync_mem[wr_idx] <= new_sync_i;
         addr_mem[wr_idx] <= new_addr_i;
      end
   end

   assign reconv_o = reconv_hit;
   assign cnt_o    = cnt_q;
   assign hwm_o    = hwm_q;
   assign full_o   = full;
   assign empty_o  = empty;
   assign ovf_o    = ovf_q;
   assign udf_o    = udf_q;

endmodule

// File: tb/tb_simt_reconv_stack.sv
// Directed bench for simt_reconv_stack with THREADS=4, DEPTH=4, WORD_W=32.
module tb_simt_reconv_stack;

   logic        clk = 1'b0;
   logic        RST;
   logic        push_i, pop_i, pc_valid_i, err_clr_i;
   logic [3:0]  new_mask_i;
   logic [31:0] new_sync_i, new_addr_i, pc_i;
   logic [3:0]  top_mask_o;
   logic [31:0] top_sync_o, top_addr_o;
   logic        reconv_o, full_o, empty_o, ovf_o, udf_o;
   logic [2:0]  cnt_o, hwm_o;

   int total = 0;
   int bad   = 0;

   simt_reconv_stack #(.THREADS(4), .DEPTH(4), .WORD_W(32)) dut (
      .clk(clk), .RST(RST), .push_i(push_i), .pop_i(pop_i),
      .new_mask_i(new_mask_i), .new_sync_i(new_sync_i), .new_addr_i(new_addr_i),
      .pc_valid_i(pc_valid_i), .pc_i(pc_i), .err_clr_i(err_clr_i),
      .top_mask_o(top_mask_o), .top_sync_o(top_sync_o), .top_addr_o(top_addr_o),
      .reconv_o(reconv_o), .cnt_o(cnt_o), .hwm_o(hwm_o),
      .full_o(full_o), .empty_o(empty_o), .ovf_o(ovf_o), .udf_o(udf_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs are changed and outputs sampled 1 unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_new(input logic [3:0] m, input logic [31:0] s, input logic [31:0] a);
      new_mask_i = m;
      new_sync_i = s;
      new_addr_i = a;
   endtask

   initial begin
      RST = 1'b1; push_i = 1'b0; pop_i = 1'b0; pc_valid_i = 1'b0;
      err_clr_i = 1'b0; pc_i = '0; set_new('0, '0, '0);
      step(); step();
      RST = 1'b0;
      step();

      // Reset then idle
      chk("rst_cnt",   cnt_o, 0);
      chk("rst_empty", empty_o, 1);
      chk("rst_full",  full_o, 0);
      chk("rst_mask",  top_mask_o, 4'b1111);
      chk("rst_sync",  top_sync_o, 0);
      chk("rst_addr",  top_addr_o, 0);
      chk("rst_ovf",   ovf_o, 0);
      chk("rst_udf",   udf_o, 0);
      chk("rst_hwm",   hwm_o, 0);

      // Empty stack with pc matching the default sync (0) must not reconverge
      pc_valid_i = 1'b1; pc_i = 32'h0;
      #1 chk("empty_no_reconv", reconv_o, 0);
      pc_valid_i = 1'b0;

      // Two pushes
      push_i = 1'b1; set_new(4'b0011, 32'h40, 32'h10); step();
      chk("push1_addr", top_addr_o, 32'h10);
      set_new(4'b1100, 32'h40, 32'h20); step();
      push_i = 1'b0;
      chk("push2_cnt",  cnt_o, 2);
      chk("push2_mask", top_mask_o, 4'b1100);
      chk("push2_addr", top_addr_o, 32'h20);
      chk("push2_sync", top_sync_o, 32'h40);
      chk("push2_hwm",  hwm_o, 2);

      // Reconvergence together with explicit pop: one entry only
      pc_valid_i = 1'b1; pc_i = 32'h40; pop_i = 1'b1;
      #1 chk("reconv_o", reconv_o, 1);
      step();
      pop_i = 1'b0; pc_valid_i = 1'b0;
      chk("reconv_cnt",  cnt_o, 1);
      chk("reconv_addr", top_addr_o, 32'h10);
      chk("reconv_mask", top_mask_o, 4'b0011);
      chk("reconv_udf",  udf_o, 0);

      // Reconvergence alone pops the last entry
      pc_valid_i = 1'b1; pc_i = 32'h40; step();
      pc_valid_i = 1'b0;
      chk("reconv2_cnt",   cnt_o, 0);
      chk("reconv2_empty", empty_o, 1);
      chk("reconv2_mask",  top_mask_o, 4'b1111);
      chk("reconv2_hwm",   hwm_o, 2);

      // Five pushes into a depth-4 stack
      push_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_new(4'(i + 1), 32'h200 + i, 32'h100 + i);
         step();
      end
      chk("fill_full", full_o, 1);
      chk("fill_cnt",  cnt_o, 4);
      chk("fill_hwm",  hwm_o, 4);
      chk("fill_ovf",  ovf_o, 0);
      set_new(4'hf, 32'h204, 32'h104); step();
      push_i = 1'b0;
      chk("ovf_set",  ovf_o, 1);
      chk("ovf_cnt",  cnt_o, 4);
      chk("ovf_addr", top_addr_o, 32'h103);
      chk("ovf_mask", top_mask_o, 4'h4);
      err_clr_i = 1'b1; step();
      err_clr_i = 1'b0;
      chk("ovf_clr", ovf_o, 0);

      // Set beats clear in the same cycle
      push_i = 1'b1; err_clr_i = 1'b1; step();
      push_i = 1'b0; err_clr_i = 1'b0;
      chk("ovf_set_wins", ovf_o, 1);
      err_clr_i = 1'b1; step();
      err_clr_i = 1'b0;
      chk("ovf_clr2", ovf_o, 0);

      // Full stack replace
      push_i = 1'b1; pop_i = 1'b1; set_new(4'b0101, 32'h300, 32'h99); step();
      push_i = 1'b0; pop_i = 1'b0;
      chk("repl_cnt",  cnt_o, 4);
      chk("repl_addr", top_addr_o, 32'h99);
      chk("repl_mask", top_mask_o, 4'b0101);
      chk("repl_ovf",  ovf_o, 0);
      chk("repl_full", full_o, 1);

      // Pop exposes previous entry
      pop_i = 1'b1; step();
      chk("pop_cnt",  cnt_o, 3);
      chk("pop_addr", top_addr_o, 32'h102);
      chk("pop_sync", top_sync_o, 32'h202);
      step(); step(); step();
      pop_i = 1'b0;
      chk("drain_empty", empty_o, 1);
      chk("drain_udf",   udf_o, 0);

      // Underflow
      pop_i = 1'b1; step();
      pop_i = 1'b0;
      chk("udf_set", udf_o, 1);
      chk("udf_cnt", cnt_o, 0);

      // Push+pop on empty
      push_i = 1'b1; pop_i = 1'b1; set_new(4'b1010, 32'h500, 32'h55); step();
      push_i = 1'b0; pop_i = 1'b0;
      chk("pp_cnt",  cnt_o, 1);
      chk("pp_udf",  udf_o, 1);
      chk("pp_addr", top_addr_o, 32'h55);
      chk("pp_hwm",  hwm_o, 4);

      // Reset overrides a concurrent push
      RST = 1'b1; push_i = 1'b1; step();
      RST = 1'b0; push_i = 1'b0;
      chk("rst2_cnt",  cnt_o, 0);
      chk("rst2_hwm",  hwm_o, 0);
      chk("rst2_udf",  udf_o, 0);
      chk("rst2_ovf",  ovf_o, 0);
      chk("rst2_mask", top_mask_o, 4'b1111);
      chk("rst2_empty", empty_o, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
